// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate D-cache
// controller for the MEM stage, one word per line.
module dcache_ctrl #(
  parameter int ADDR_W     = 22,
  parameter int DATA_W     = 32,
  parameter int INDEX_BITS = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              cache_hit,
  output logic              stall,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic [15:0]       miss_cnt
);

  localparam int TAG_W = ADDR_W - INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] data_q [LINES];
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINES-1:0]  valid_q, valid_d;
  logic [LINES-1:0]  dirty_q, dirty_d;
  logic [15:0]       miss_cnt_q, miss_cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic                  req;
  logic                  hit;
  logic                  data_we;
  logic [DATA_W-1:0]     data_wv;
  logic                  tag_we;

  assign idx = addr[INDEX_BITS-1:0];
  assign tag = addr[ADDR_W-1:INDEX_BITS];
  // Gated by rst_n so every output reads zero while reset is held.
  assign req = (re | we) & rst_n;
  assign hit = valid_q[idx] & (tag_q[idx] == tag);

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    miss_cnt_d = miss_cnt_q;
    rdata_d    = rdata_q;
    data_we    = 1'b0;
    data_wv    = wdata;
    tag_we     = 1'b0;
    cache_hit  = 1'b0;
    stall      = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    unique case (state_q)
      IDLE: begin
        if (req && hit) begin
          cache_hit = 1'b1;
          if (we) begin
            data_we      = 1'b1;
            dirty_d[idx] = 1'b1;
          end else begin
            rdata_d = data_q[idx];
          end
        end else if (req) begin
          stall = 1'b1;
          if (miss_cnt_q != 16'hFFFF)
            miss_cnt_d = miss_cnt_q + 16'd1;
          if (valid_q[idx] && dirty_q[idx])
            state_d = WRITEBACK;
          else
            state_d = FILL;
        end
      end
      WRITEBACK: begin
        stall     = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[idx], idx};
        mem_wdata = data_q[idx];
        if (mem_rdy) begin
          dirty_d[idx] = 1'b0;
          state_d      = FILL;
        end
      end
      FILL: begin
        stall    = 1'b1;
        mem_re   = 1'b1;
        mem_addr = addr;
        if (mem_rdy) begin
          data_we      = 1'b1;
          data_wv      = mem_rdata;
          tag_we       = 1'b1;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdata    = rdata_d;
  assign miss_cnt = miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      miss_cnt_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      miss_cnt_q <= miss_cnt_d;
      rdata_q    <= rdata_d;
    end
  end

  // Line storage needs no reset; valid bits qualify it.
  always_ff @(posedge clk) begin
    if (data_we)
      data_q[idx] <= data_wv;
    if (tag_we)
      tag_q[idx] <= tag;
  end

endmodule
